// File: rtl/node_flit_source_pkg.sv
// node_flit_source_pkg
//   Shared definitions for node_flit_source:
//   - FSM state encodings
//   - injection-rate denominator and LFSR scale
//   - channel_out field offsets, {valid, vc, head, tail, data} MSB first
//   - clogb helper used for derived widths
package node_flit_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_e;

  // Injection attempts are expressed per RATE_DENOM cycles; the hit test
  // scales that onto the 14-bit LFSR window (0..RATE_SCALE-1).
  localparam int RATE_DENOM = 10000;
  localparam int RATE_SCALE = 16384;

  // Width needed to index n items; never less than one bit.
  function automatic int clogb(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // channel_out field offsets for a given vc index width and data width.
  localparam int CO_DATA_LSB = 0;

  function automatic int co_tail_pos(input int dw);
    return dw;
  endfunction

  function automatic int co_head_pos(input int dw);
    return dw + 1;
  endfunction

  function automatic int co_vc_lsb(input int dw);
    return dw + 2;
  endfunction

  function automatic int co_valid_pos(input int vw, input int dw);
    return dw + vw + 2;
  endfunction

endpackage

// File: rtl/node_flit_source_lfsr.sv
// nfs_lfsr32
//   Seedable 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, advancing
//   every cycle out of reset. A zero seed is replaced by 1 so the register
//   never locks up.
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset (loads the seed)
//   hit_bits_o  state[31:18], compared against the injection threshold
//   len_bits_o  state[15:0], used to pick the packet length
module nfs_lfsr32 #(
  parameter logic [31:0] SEED = 32'd1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [13:0] hit_bits_o,
  output logic [15:0] len_bits_o
);

  // Right-shifting Galois form: taps 32,22,2,1 map to mask bits 31,21,1,0.
  localparam logic [31:0] POLY     = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  // Next LFSR state.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'd0);
  end

  // LFSR state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign hit_bits_o = lfsr_q[31:18];
  assign len_bits_o = lfsr_q[15:0];

endmodule

// File: rtl/node_flit_source.sv
// node_flit_source
//   Credit-based packet source for one router input port. Starts packets at a
//   programmable pseudo-random rate, segments them into head/body/tail flits
//   and keeps per-VC credit counters so the router buffer cannot overflow.
// Ports:
//   clk           clock
//   reset         asynchronous active-low reset
//   channel_out   registered flit {valid, vc, head, tail, data}
//   flow_ctrl_in  credit return {valid, vc}
//   enable        permits new packet starts
//   packet_count  completed packets (tail sent)
//   busy          packet in flight
//   error         sticky credit-overflow flag
module node_flit_source
  import node_flit_source_pkg::*;
#(
  parameter int          num_vcs            = 4,
  parameter int          buffer_size        = 8,
  parameter int          flit_data_width    = 64,
  parameter int          min_payload_length = 1,
  parameter int          max_payload_length = 4,
  parameter int          packet_rate        = 1000,
  parameter int          max_packet_count   = -1,
  parameter logic [31:0] initial_seed       = 32'd0,
  localparam int         vc_idx_width       = clogb(num_vcs)
) (
  input  logic                                        clk,
  input  logic                                        reset,
  output logic [3+vc_idx_width+flit_data_width-1:0]   channel_out,
  input  logic [vc_idx_width:0]                       flow_ctrl_in,
  input  logic                                        enable,
  output logic [31:0]                                 packet_count,
  output logic                                        busy,
  output logic                                        error
);

  localparam int VW   = vc_idx_width;
  localparam int DW   = flit_data_width;
  localparam int FW   = 3 + VW + DW;
  localparam int CW   = clogb(buffer_size + 1);
  localparam int LW   = clogb(max_payload_length + 1);
  localparam int SPAN = max_payload_length - min_payload_length + 1;

  localparam int VALID_POS = co_valid_pos(VW, DW);
  localparam int VC_LSB    = co_vc_lsb(DW);
  localparam int HEAD_POS  = co_head_pos(DW);
  localparam int TAIL_POS  = co_tail_pos(DW);

  localparam logic [14:0]   RATE_THRESH = 15'((packet_rate * RATE_SCALE) / RATE_DENOM);
  localparam logic [CW-1:0] BUF_FULL    = CW'(buffer_size);
  localparam bit            LIMITED     = (max_packet_count >= 0);
  localparam logic [31:0]   LIMIT       = 32'(max_packet_count);

  state_e          state_q;
  logic [VW-1:0]   vc_q;
  logic [VW-1:0]   rr_ptr_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   idx_q;
  logic [31:0]     packet_count_q;
  logic            busy_q;
  logic            error_q;
  logic [FW-1:0]   channel_out_q;
  logic [CW-1:0]   credit_q [num_vcs];
  logic [CW-1:0]   credit_d [num_vcs];

  logic [13:0]     hit_bits_s;
  logic [15:0]     len_bits_s;
  logic            hit_s;
  logic            limit_s;
  logic            pick_found_s;
  logic [VW-1:0]   pick_vc_s;
  logic [LW-1:0]   len_pick_s;
  logic            start_s;
  logic            send_s;
  logic            tail_s;
  logic [DW-1:0]   data_s;
  logic [FW-1:0]   flit_s;
  logic            ovf_s;
  logic            ret_valid_s;
  logic [VW-1:0]   ret_vc_s;

  nfs_lfsr32 #(
    .SEED (initial_seed)
  ) u_lfsr (
    .clk_i      (clk),
    .rst_ni     (reset),
    .hit_bits_o (hit_bits_s),
    .len_bits_o (len_bits_s)
  );

  assign ret_valid_s = flow_ctrl_in[VW];
  assign ret_vc_s    = flow_ctrl_in[VW-1:0];

  // Start decision: rate hit, limit, and round-robin pick of a VC with credit.
  always_comb begin
    hit_s        = ({1'b0, hit_bits_s} < RATE_THRESH);
    limit_s      = LIMITED && (packet_count_q == LIMIT);
    len_pick_s   = LW'(32'(min_payload_length) + (32'(len_bits_s) % 32'(SPAN)));
    pick_found_s = 1'b0;
    pick_vc_s    = '0;
    // Search begins one past the last VC used, wrapping around.
    for (int k = 1; k <= num_vcs; k++) begin
      if (!pick_found_s && (credit_q[VW'((int'(rr_ptr_q) + k) % num_vcs)] != '0)) begin
        pick_found_s = 1'b1;
        pick_vc_s    = VW'((int'(rr_ptr_q) + k) % num_vcs);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
    start_s = (state_q == ST_IDLE) && enable && hit_s && !limit_s && pick_found_s;
    send_s  = ((state_q == ST_HEAD) || (state_q == ST_BODY)) && (credit_q[vc_q] != '0);
  end

  // Flit assembly for the current HEAD/BODY state.
  always_comb begin
    case (state_q)
      ST_HEAD: begin
        tail_s = (len_q == '0);
        data_s = DW'(packet_count_q);
      end
      ST_BODY: begin
        tail_s = (idx_q == len_q);
        data_s = DW'(idx_q);
      end
      default: begin
        tail_s = 1'b0;
        data_s = '0;
      end
    endcase
    flit_s                  = '0;
    flit_s[VALID_POS]       = 1'b1;
    flit_s[VC_LSB +: VW]    = vc_q;
    flit_s[HEAD_POS]        = (state_q == ST_HEAD);
    flit_s[TAIL_POS]        = tail_s;
    flit_s[CO_DATA_LSB +: DW] = data_s;
  end

  // Credit next-state: a send and a return on the same VC cancel out; a
  // return at full credit is an overflow and the counter saturates.
  always_comb begin
    ovf_s = 1'b0;
    for (int v = 0; v < num_vcs; v++) begin
      if (send_s && (vc_q == VW'(v)) && !(ret_valid_s && (ret_vc_s == VW'(v)))) begin
        credit_d[v] = credit_q[v] - CW'(1);
      end else if (ret_valid_s && (ret_vc_s == VW'(v)) && !(send_s && (vc_q == VW'(v)))) begin
        if (credit_q[v] == BUF_FULL) begin
          ovf_s       = 1'b1;
          credit_d[v] = credit_q[v];
        end else begin
          credit_d[v] = credit_q[v] + CW'(1);
        end
      end else begin
        credit_d[v] = credit_q[v];
      end
    end
  end

  // Credit counters and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < num_vcs; v++) begin
        credit_q[v] <= BUF_FULL;
      end
      error_q <= 1'b0;
    end else begin
      credit_q <= credit_d;
      error_q  <= error_q | ovf_s;
    end
  end

  // Packet FSM with registered flit, count and busy outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      vc_q           <= '0;
      rr_ptr_q       <= VW'(num_vcs - 1);
      len_q          <= '0;
      idx_q          <= '0;
      packet_count_q <= 32'd0;
      busy_q         <= 1'b0;
      channel_out_q  <= '0;
    end else begin
      channel_out_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (start_s) begin
            state_q  <= ST_HEAD;
            vc_q     <= pick_vc_s;
            rr_ptr_q <= pick_vc_s;
            len_q    <= len_pick_s;
            busy_q   <= 1'b1;
          end
        end
        ST_HEAD, ST_BODY: begin
          if (send_s) begin
            channel_out_q <= flit_s;
            idx_q         <= (state_q == ST_HEAD) ? LW'(1) : idx_q + LW'(1);
            if (tail_s) begin
              state_q        <= ST_IDLE;
              packet_count_q <= packet_count_q + 32'd1;
              busy_q         <= 1'b0;
            end else begin
              state_q <= ST_BODY;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign channel_out  = channel_out_q;
  assign packet_count = packet_count_q;
  assign busy         = busy_q;
  assign error        = error_q;

endmodule

// File: tb/tb_node_flit_source.sv
// tb_node_flit_source
//   Three source instances (A: 8 credits, 3-flit packets; B: 2 credits,
//   3-flit packets; C: 2-flit packets, limit of 3). Scenarios run one at a
//   time; expected flits go into one queue and a monitor pops and compares
//   every valid flit it sees on any instance.
module tb_node_flit_source;

  localparam int CW = 69;

  logic clk;
  logic [2:0] rst_v;
  logic [2:0] en_v;
  logic [2:0][2:0] fc_v;
  wire  [2:0][CW-1:0] ch_v;
  wire  [2:0][31:0] cnt_v;
  wire  [2:0] busy_v;
  wire  [2:0] err_v;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_cyc [3] = '{-10, -10, -10};

  typedef struct packed {
    logic [1:0]  inst;
    logic [1:0]  vc;
    logic        head;
    logic        tail;
    logic        b2b;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  node_flit_source #(.num_vcs(4), .buffer_size(8), .flit_data_width(64),
    .min_payload_length(2), .max_payload_length(2), .packet_rate(10000),
    .max_packet_count(-1), .initial_seed(32'd0)) u_a (
    .clk(clk), .reset(rst_v[0]), .channel_out(ch_v[0]), .flow_ctrl_in(fc_v[0]),
    .enable(en_v[0]), .packet_count(cnt_v[0]), .busy(busy_v[0]), .error(err_v[0]));

  node_flit_source #(.num_vcs(4), .buffer_size(2), .flit_data_width(64),
    .min_payload_length(2), .max_payload_length(2), .packet_rate(10000),
    .max_packet_count(-1), .initial_seed(32'd5)) u_b (
    .clk(clk), .reset(rst_v[1]), .channel_out(ch_v[1]), .flow_ctrl_in(fc_v[1]),
    .enable(en_v[1]), .packet_count(cnt_v[1]), .busy(busy_v[1]), .error(err_v[1]));

  node_flit_source #(.num_vcs(4), .buffer_size(8), .flit_data_width(64),
    .min_payload_length(1), .max_payload_length(1), .packet_rate(10000),
    .max_packet_count(3), .initial_seed(32'd9)) u_c (
    .clk(clk), .reset(rst_v[2]), .channel_out(ch_v[2]), .flow_ctrl_in(fc_v[2]),
    .enable(en_v[2]), .packet_count(cnt_v[2]), .busy(busy_v[2]), .error(err_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_flit(input logic [1:0] inst, input logic [1:0] vc, input logic head,
                             input logic tail, input logic b2b, input logic [63:0] data);
    exp_t e;
    e.inst = inst; e.vc = vc; e.head = head; e.tail = tail; e.b2b = b2b; e.data = data;
    exp_q.push_back(e);
  endtask

  // Expect a 3-flit packet (head=seq, body 1, tail 2) on the given vc.
  task automatic expect_pkt3(input logic [1:0] inst, input logic [1:0] vc, input logic [63:0] seq);
    expect_flit(inst, vc, 1'b1, 1'b0, 1'b0, seq);
    expect_flit(inst, vc, 1'b0, 1'b0, 1'b1, 64'd1);
    expect_flit(inst, vc, 1'b0, 1'b1, 1'b1, 64'd2);
  endtask

  // Pulse enable until exactly one packet has started.
  task automatic start_one(input int i);
    bit ok;
    ok = 1'b0;
    en_v[i] = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (busy_v[i]) ok = 1'b1;
    end
    en_v[i] = 1'b0;
    chk("start_timeout", {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_idle(input int i);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (!busy_v[i]) ok = 1'b1;
    end
    chk("idle_timeout", {63'd0, ok}, 64'd1);
  endtask

  // Monitor: every valid flit must match the head of the expected queue.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ch_v[i][68]) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_flit: inst %0d got %0h, required no flit (cycle %0d)", i, ch_v[i], cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("flit_ctl", {58'd0, i[1:0], ch_v[i][67:66], ch_v[i][65], ch_v[i][64]},
              {58'd0, mon_e.inst, mon_e.vc, mon_e.head, mon_e.tail});
          chk("flit_data", ch_v[i][63:0], mon_e.data);
          if (mon_e.b2b) chk("flit_b2b", 64'(cyc), 64'(last_cyc[i] + 1));
        end
        last_cyc[i] = cyc;
      end
    end
  end

  initial begin
    rst_v = 3'b000;
    en_v  = 3'b001;
    fc_v  = '0;

    // Reset hold with enable high on A.
    repeat (3) @(negedge clk);
    chk("rst_channel_out", ch_v[0][63:0] | 64'(ch_v[0][68:64]), 64'd0);
    chk("rst_packet_count", 64'(cnt_v[0]), 64'd0);
    chk("rst_busy", 64'(busy_v[0]), 64'd0);
    chk("rst_error", 64'(err_v[0]), 64'd0);
    en_v  = 3'b000;
    rst_v = 3'b111;
    repeat (2) @(negedge clk);

    // A: back-to-back packet on vc0.
    expect_pkt3(2'd0, 2'd0, 64'd0);
    start_one(0);
    wait_idle(0);
    chk("a_count_1", 64'(cnt_v[0]), 64'd1);

    // A: credit return on untouched vc1 (full) -> overflow.
    fc_v[0] = {1'b1, 2'd1};
    @(negedge clk);
    fc_v[0] = '0;
    chk("a_overflow_err", 64'(err_v[0]), 64'd1);

    // A: next packet goes round-robin to vc1; error stays set.
    expect_pkt3(2'd0, 2'd1, 64'd1);
    start_one(0);
    wait_idle(0);
    chk("a_count_2", 64'(cnt_v[0]), 64'd2);
    chk("a_err_sticky", 64'(err_v[0]), 64'd1);

    // A: reset asserted during BODY of the vc2 packet.
    expect_flit(2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 64'd2);
    start_one(0);
    @(negedge clk);
    #2 rst_v[0] = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(ch_v[0][68]), 64'd0);
    chk("mid_rst_busy", 64'(busy_v[0]), 64'd0);
    chk("mid_rst_count", 64'(cnt_v[0]), 64'd0);
    chk("mid_rst_err", 64'(err_v[0]), 64'd0);
    rst_v[0] = 1'b1;
    expect_pkt3(2'd0, 2'd0, 64'd0);
    start_one(0);
    wait_idle(0);
    chk("a_count_after_rst", 64'(cnt_v[0]), 64'd1);

    // B: two credits only -> head and body, then stall.
    expect_flit(2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 64'd0);
    expect_flit(2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 64'd1);
    start_one(1);
    repeat (10) @(negedge clk);
    chk("b_stalled_busy", 64'(busy_v[1]), 64'd1);
    chk("b_stalled_count", 64'(cnt_v[1]), 64'd0);
    expect_flit(2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 64'd2);
    fc_v[1] = {1'b1, 2'd0};
    @(negedge clk);
    fc_v[1] = '0;
    wait_idle(1);
    chk("b_count_1", 64'(cnt_v[1]), 64'd1);
    repeat (8) @(negedge clk);

    // B: vc1 credit returned on every send cycle -> no stall with 2 credits.
    expect_pkt3(2'd1, 2'd1, 64'd1);
    start_one(1);
    fc_v[1] = {1'b1, 2'd1};
    repeat (3) @(negedge clk);
    fc_v[1] = '0;
    wait_idle(1);
    chk("b_count_2", 64'(cnt_v[1]), 64'd2);
    chk("b_no_error", 64'(err_v[1]), 64'd0);

    // C: enable held high, limit of 3 packets (head + tail each).
    for (int p = 0; p < 3; p++) begin
      expect_flit(2'd2, 2'(p), 1'b1, 1'b0, 1'b0, 64'(p));
      expect_flit(2'd2, 2'(p), 1'b0, 1'b1, 1'b1, 64'd1);
    end
    en_v[2] = 1'b1;
    repeat (40) @(negedge clk);
    chk("c_count_limit", 64'(cnt_v[2]), 64'd3);
    chk("c_busy_limit", 64'(busy_v[2]), 64'd0);
    en_v[2] = 1'b0;

    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
